// File: rtl/operand_fetch_if.sv
// Operand-fetch bus bundle: fetch handshake, register-file read port, writeback, execute handshake.
// Purely combinational wiring, no latency of its own.
// Back-pressure is carried by ifReady (towards fetch) and exReady (from execute).
interface operand_fetch_if;
  logic        ifValid;
  logic [15:0] ifInstr;
  logic [15:0] ifPC;
  logic        ifReady;
  logic [2:0]  rfReadAdd1;
  logic [2:0]  rfReadAdd2;
  logic [15:0] rfOut1;
  logic [15:0] rfOut2;
  logic        wbWrite;
  logic [2:0]  wbAdd;
  logic [15:0] wbData;
  logic        exValid;
  logic        exReady;
  logic [15:0] exInstr;
  logic [15:0] exPC;
  logic [15:0] exSrc1;
  logic [15:0] exSrc2;
  logic [2:0]  exDest;
  logic        exWrites;

  // The operand-fetch stage itself.
  modport master (
    input  ifValid, ifInstr, ifPC, rfOut1, rfOut2, wbWrite, wbAdd, wbData, exReady,
    output ifReady, rfReadAdd1, rfReadAdd2, exValid, exInstr, exPC, exSrc1, exSrc2,
           exDest, exWrites
  );

  // Fetch, register file, writeback and execute seen from outside the stage.
  modport slave (
    output ifValid, ifInstr, ifPC, rfOut1, rfOut2, wbWrite, wbAdd, wbData, exReady,
    input  ifReady, rfReadAdd1, rfReadAdd2, exValid, exInstr, exPC, exSrc1, exSrc2,
           exDest, exWrites
  );
endinterface

// File: rtl/operand_fetch.sv
// LC-3b operand fetch: decode, register read with writeback forwarding, 8-entry write scoreboard.
// Latency one cycle: an instruction accepted at an edge is on the ex* outputs right after it.
// ifReady drops on a RAW/WAW hazard or while execute holds an unconsumed instruction.
module operand_fetch (
  input logic clk,
  input logic reset,
  operand_fetch_if.master bus
);

  logic [3:0]  op;
  logic        use1;
  logic        use2;
  logic        writes;
  logic [2:0]  dest;
  logic [2:0]  add1;
  logic [2:0]  add2;
  logic [15:0] src1;
  logic [15:0] src2;
  logic [7:0]  pending;
  logic [7:0]  clr;
  logic [7:0]  set;
  logic [7:0]  ep;
  logic        hazard;
  logic        ready;
  logic        dispatch;

  logic        ex_valid;
  logic [15:0] ex_instr;
  logic [15:0] ex_pc;
  logic [15:0] ex_src1;
  logic [15:0] ex_src2;
  logic [2:0]  ex_dest;
  logic        ex_writes;

  assign op = bus.ifInstr[15:12];

  // Register read addresses: stores read their data register through port 2.
  always_comb begin
    add1 = bus.ifInstr[8:6];
    add2 = bus.ifInstr[2:0];
    if (op == 4'b0011 || op == 4'b0111) begin
      add2 = bus.ifInstr[11:9];
    end
  end

  // Source usage, register write and destination decode per opcode.
  always_comb begin
    use1   = 1'b0;
    use2   = 1'b0;
    writes = 1'b0;
    dest   = bus.ifInstr[11:9];
    case (op)
      4'b0001, 4'b0101, 4'b1001: begin   // ADD, AND, XOR
        use1   = 1'b1;
        use2   = !bus.ifInstr[5];
        writes = 1'b1;
      end
      4'b1101, 4'b0010, 4'b0110: begin   // SHF, LDB, LDW
        use1   = 1'b1;
        writes = 1'b1;
      end
      4'b0011, 4'b0111: begin            // STB, STW
        use1 = 1'b1;
        use2 = 1'b1;
      end
      4'b1100: begin                     // JMP / RET
        use1 = 1'b1;
      end
      4'b0100: begin                     // JSR / JSRR link into R7
        use1   = !bus.ifInstr[11];
        writes = 1'b1;
        dest   = 3'd7;
      end
      4'b1110: begin                     // LEA
        writes = 1'b1;
      end
      4'b1111: begin                     // TRAP links into R7
        writes = 1'b1;
        dest   = 3'd7;
      end
      default: begin
      end
    endcase
  end

  // Forward a writeback landing this edge; the register file still shows the old value.
  always_comb begin
    src1 = bus.rfOut1;
    src2 = bus.rfOut2;
    if (bus.wbWrite && bus.wbAdd == add1) src1 = bus.wbData;
    if (bus.wbWrite && bus.wbAdd == add2) src2 = bus.wbData;
  end

  // A register retiring this cycle no longer counts as pending, so dependents issue without a bubble.
  always_comb begin
    clr      = bus.wbWrite ? (8'd1 << bus.wbAdd) : 8'd0;
    ep       = pending & ~clr;
    hazard   = (use1 && ep[add1]) || (use2 && ep[add2]) || (writes && ep[dest]);
    ready    = !reset && !hazard && (!ex_valid || bus.exReady);
    dispatch = bus.ifValid && ready;
    set      = (dispatch && writes) ? (8'd1 << dest) : 8'd0;
  end

  // Scoreboard update; a new set on a register beats its retiring clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 8'd0;
    end else begin
      pending <= (pending & ~clr) | set;
    end
  end

  // One-entry execute register: load on dispatch, drop valid on consume, otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid  <= 1'b0;
      ex_instr  <= 16'd0;
      ex_pc     <= 16'd0;
      ex_src1   <= 16'd0;
      ex_src2   <= 16'd0;
      ex_dest   <= 3'd0;
      ex_writes <= 1'b0;
    end else if (dispatch) begin
      ex_valid  <= 1'b1;
      ex_instr  <= bus.ifInstr;
      ex_pc     <= bus.ifPC;
      ex_src1   <= src1;
      ex_src2   <= src2;
      ex_dest   <= dest;
      ex_writes <= writes;
    end else if (ex_valid && bus.exReady) begin
      ex_valid <= 1'b0;
    end
  end

  assign bus.ifReady    = ready;
  assign bus.rfReadAdd1 = add1;
  assign bus.rfReadAdd2 = add2;
  assign bus.exValid    = ex_valid;
  assign bus.exInstr    = ex_instr;
  assign bus.exPC       = ex_pc;
  assign bus.exSrc1     = ex_src1;
  assign bus.exSrc2     = ex_src2;
  assign bus.exDest     = ex_dest;
  assign bus.exWrites   = ex_writes;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed pipeline scenarios followed by random traffic.
// Expected ex* contents are queued at dispatch and popped by a monitor when execute consumes.
// A register-file array in the bench feeds rfOut and absorbs writebacks.
module tb_operand_fetch;

  logic clk = 1'b0;
  logic reset;
  operand_fetch_if bus();

  operand_fetch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] src1;
    logic [15:0] src2;
    logic [2:0]  dest;
    logic        writes;
  } exp_t;

  logic [15:0] regs [8];
  bit          mpend [8];
  bit          mexv;
  exp_t        q [$];
  int          nvec = 0;
  int          nerr = 0;

  assign bus.rfOut1 = regs[bus.rfReadAdd1];
  assign bus.rfOut2 = regs[bus.rfReadAdd2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Instruction semantics straight from the ISA: which registers are read, written, and where.
  function automatic void ref_decode(input logic [15:0] i, output bit u1, output bit u2,
                                     output bit w, output logic [2:0] a1,
                                     output logic [2:0] a2, output logic [2:0] d);
    int o;
    o  = int'(i[15:12]);
    a1 = i[8:6];
    a2 = (o == 3 || o == 7) ? i[11:9] : i[2:0];
    u1 = (o inside {1, 5, 9, 13, 2, 6, 3, 7, 12}) || (o == 4 && i[11] == 1'b0);
    u2 = ((o inside {1, 5, 9}) && i[5] == 1'b0) || (o inside {3, 7});
    w  = o inside {1, 5, 9, 13, 2, 6, 14, 4, 15};
    d  = (o == 4 || o == 15) ? 3'd7 : i[11:9];
  endfunction

  function automatic logic [7:0] model_pending();
    logic [7:0] p;
    for (int r = 0; r < 8; r++) p[r] = mpend[r];
    return p;
  endfunction

  task automatic flush_model();
    q.delete();
    for (int r = 0; r < 8; r++) mpend[r] = 1'b0;
    mexv = 1'b0;
  endtask

  // One clock cycle: drive, check comb outputs mid-cycle, predict dispatch, then retire the edge.
  task automatic step(input bit v, input logic [15:0] instr, input logic [15:0] pc,
                      input bit wb, input logic [2:0] wa, input logic [15:0] wd, input bit er);
    bit u1, u2, w, r1busy, r2busy, dbusy, exp_rdy, disp;
    logic [2:0] a1, a2, d;
    exp_t e;
    bus.ifValid = v;
    bus.ifInstr = instr;
    bus.ifPC    = pc;
    bus.wbWrite = wb;
    bus.wbAdd   = wa;
    bus.wbData  = wd;
    bus.exReady = er;
    @(negedge clk);
    ref_decode(instr, u1, u2, w, a1, a2, d);
    // A register is busy while a write is outstanding and not landing this cycle.
    r1busy  = mpend[a1] && !(wb && wa == a1);
    r2busy  = mpend[a2] && !(wb && wa == a2);
    dbusy   = mpend[d]  && !(wb && wa == d);
    exp_rdy = !((u1 && r1busy) || (u2 && r2busy) || (w && dbusy)) && (!mexv || er);
    chk("rfReadAdd1", 32'(bus.rfReadAdd1), 32'(a1));
    chk("rfReadAdd2", 32'(bus.rfReadAdd2), 32'(a2));
    chk("ifReady",    32'(bus.ifReady),    32'(exp_rdy));
    chk("exValid",    32'(bus.exValid),    32'(mexv));
    disp = v && exp_rdy;
    if (disp) begin
      e.instr  = instr;
      e.pc     = pc;
      e.src1   = (wb && wa == a1) ? wd : regs[a1];
      e.src2   = (wb && wa == a2) ? wd : regs[a2];
      e.dest   = d;
      e.writes = w;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (wb) begin
      mpend[wa] = 1'b0;
      regs[wa]  = wd;
    end
    if (disp && w) mpend[d] = 1'b1;
    if (disp) mexv = 1'b1;
    else if (er) mexv = 1'b0;
  endtask

  // Monitor: every consumed execute slot must match the oldest dispatched instruction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && bus.exValid === 1'b1 && bus.exReady === 1'b1) begin
        if (q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL ex_unexpected: got instr %0h, expected no instruction", bus.exInstr);
        end else begin
          e = q.pop_front();
          chk("exInstr",  32'(bus.exInstr),  32'(e.instr));
          chk("exPC",     32'(bus.exPC),     32'(e.pc));
          chk("exSrc1",   32'(bus.exSrc1),   32'(e.src1));
          chk("exSrc2",   32'(bus.exSrc2),   32'(e.src2));
          chk("exDest",   32'(bus.exDest),   32'(e.dest));
          chk("exWrites", 32'(bus.exWrites), 32'(e.writes));
        end
      end
    end
  end

  initial begin
    logic [2:0]  plist [$];
    logic [2:0]  wa;
    bit          wb;
    for (int r = 0; r < 8; r++) regs[r] = 16'(r * 16'h1111 + 16'h0101);
    flush_model();
    bus.ifValid = 1'b0;
    bus.ifInstr = 16'h0000;
    bus.ifPC    = 16'h0000;
    bus.wbWrite = 1'b0;
    bus.wbAdd   = 3'd0;
    bus.wbData  = 16'h0000;
    bus.exReady = 1'b1;

    // Reset state
    reset = 1'b1;
    #2;
    chk("reset_exValid", 32'(bus.exValid), 32'd0);
    chk("reset_ifReady", 32'(bus.ifReady), 32'd0);
    chk("reset_exInstr", 32'(bus.exInstr), 32'd0);
    chk("reset_pending", 32'(dut.pending), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // ADD R1,R2,R3 dispatches immediately
    step(1'b1, 16'h1283, 16'h3000, 1'b0, 3'd0, 16'h0, 1'b1);
    chk("add_exValid",  32'(bus.exValid),  32'd1);
    chk("add_exDest",   32'(bus.exDest),   32'd1);
    chk("add_exWrites", 32'(bus.exWrites), 32'd1);
    chk("add_pending",  32'(dut.pending),  32'h02);

    // ADD R4,R1,R1 stalls on R1 until its writeback, which is forwarded
    repeat (3) step(1'b1, 16'h1841, 16'h3002, 1'b0, 3'd0, 16'h0, 1'b1);
    step(1'b1, 16'h1841, 16'h3002, 1'b1, 3'd1, 16'h1234, 1'b1);
    chk("fwd_exSrc1",  32'(bus.exSrc1),  32'h1234);
    chk("fwd_exSrc2",  32'(bus.exSrc2),  32'h1234);
    chk("fwd_pending", 32'(dut.pending), 32'h10);

    // Execute back-pressure holds the register and blocks fetch
    repeat (3) begin
      step(1'b1, 16'h14C3, 16'h3004, 1'b0, 3'd0, 16'h0, 1'b0);
      chk("bp_exInstr", 32'(bus.exInstr), 32'h1841);
      chk("bp_exSrc1",  32'(bus.exSrc1),  32'h1234);
    end
    step(1'b0, 16'h0000, 16'h0000, 1'b0, 3'd0, 16'h0, 1'b1);
    chk("bp_drain_exValid", 32'(bus.exValid), 32'd0);
    step(1'b0, 16'h0000, 16'h0000, 1'b1, 3'd4, 16'hBEEF, 1'b1);

    // STW R5,R6,#0 reads R5 through port 2 and writes nothing
    step(1'b1, 16'h7B80, 16'h3006, 1'b0, 3'd0, 16'h0, 1'b1);
    chk("stw_exWrites", 32'(bus.exWrites), 32'd0);
    chk("stw_pending",  32'(dut.pending),  32'h00);

    // TRAP links into R7; JSRR R7 waits for that link to retire
    step(1'b1, 16'hF025, 16'h3008, 1'b0, 3'd0, 16'h0, 1'b1);
    chk("trap_exDest",  32'(bus.exDest),  32'd7);
    chk("trap_pending", 32'(dut.pending), 32'h80);
    repeat (2) step(1'b1, 16'h41C0, 16'h300A, 1'b0, 3'd0, 16'h0, 1'b1);
    step(1'b1, 16'h41C0, 16'h300A, 1'b1, 3'd7, 16'h4000, 1'b1);
    chk("jsrr_exInstr", 32'(bus.exInstr), 32'h41C0);
    step(1'b0, 16'h0000, 16'h0000, 1'b1, 3'd7, 16'h300C, 1'b1);

    // Same-edge clear and set on R3 keeps it pending
    step(1'b1, 16'h1600, 16'h3010, 1'b0, 3'd0, 16'h0, 1'b1);
    step(1'b1, 16'h1642, 16'h3012, 1'b1, 3'd3, 16'h5555, 1'b1);
    chk("waw_exInstr",  32'(bus.exInstr), 32'h1642);
    chk("waw_pending3", 32'(dut.pending), 32'h08);

    // Asynchronous reset mid-stream
    chk("pre_reset_exValid", 32'(bus.exValid), 32'd1);
    bus.ifValid = 1'b0;
    bus.wbWrite = 1'b0;
    reset = 1'b1;
    #1;
    chk("async_exValid", 32'(bus.exValid), 32'd0);
    chk("async_pending", 32'(dut.pending), 32'd0);
    flush_model();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      plist.delete();
      for (int r = 0; r < 8; r++) if (mpend[r]) plist.push_back(3'(r));
      wb = ($urandom_range(0, 2) == 0);
      if (plist.size() > 0 && $urandom_range(0, 7) != 0) wa = plist[$urandom_range(0, plist.size() - 1)];
      else wa = 3'($urandom_range(0, 7));
      step(($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom), wb, wa,
           16'($urandom), ($urandom_range(0, 3) != 0));
    end
    repeat (3) step(1'b0, 16'h0000, 16'h0000, 1'b0, 3'd0, 16'h0, 1'b1);
    chk("drain_queue", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
